// File: rtl/line_collapse.sv
// Playfield row compactor: removes full rows, shifts survivors down, zero-fills the top.
// Define LINE_SCORE_EN to add a saturating score accumulator on the score output.
module line_collapse #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int AW   = 5,
  parameter int CW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   lines_cleared
`ifdef LINE_SCORE_EN
  ,
  output logic [15:0]     score
`endif
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lines_q, lines_d;

`ifdef LINE_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  function automatic logic [15:0] line_points(input logic [CW-1:0] n);
    case (n)
      CW'(0):  line_points = 16'd0;
      CW'(1):  line_points = 16'd40;
      CW'(2):  line_points = 16'd100;
      CW'(3):  line_points = 16'd300;
      default: line_points = 16'd1200;
    endcase
  endfunction

  assign score_sum = {1'b0, score_q} + {1'b0, line_points(cnt_q)};
  assign score     = score_q;
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef LINE_SCORE_EN
    score_d = score_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = AW'(ROWS - 1);
          dst_d   = AW'(ROWS - 1);
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: state_d = EVAL;
      EVAL: begin
        if (&rd_data) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Rows below the lowest full row already sit in place.
          if (src_q != dst_q) begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            wr_data = rd_data;
          end
          dst_d = dst_q - 1'b1;
        end
        if (src_q == '0) begin
          state_d = (cnt_d != '0) ? FILL : DONE;
        end else begin
          src_d   = src_q - 1'b1;
          state_d = READ;
        end
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        if (dst_q == '0) state_d = DONE;
        else             dst_d   = dst_q - 1'b1;
      end
      DONE: begin
        lines_d = cnt_q;
`ifdef LINE_SCORE_EN
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
`ifdef LINE_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
`ifdef LINE_SCORE_EN
      score_q <= score_d;
`endif
    end
  end

  assign rd_addr       = src_q;
  assign busy          = (state_q == READ) || (state_q == EVAL) || (state_q == FILL);
  assign done          = (state_q == DONE);
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_collapse.sv
// Self-checking bench for line_collapse: RAM model, directed and random boards vs a queue-based reference.
module tb_line_collapse;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;
  localparam int CW   = 5;
  localparam logic [COLS-1:0] FULL = '1;

  logic            clk, reset, start;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
  logic            busy, done;
  logic [CW-1:0]   lines_cleared;
`ifdef LINE_SCORE_EN
  logic [15:0]     score;
  int              score_model = 0;
`endif

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] init_board [ROWS];
  logic [COLS-1:0] exp_board [ROWS];
  bit              written [ROWS];
  logic            load;
  int              exp_cnt, exp_writes, lowest_full;
  int              vectors = 0;
  int              miscompares = 0;

  line_collapse #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef LINE_SCORE_EN
    , .score(score)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read board RAM with a per-row "was written" record.
  always @(posedge clk) begin
    rd_data <= (int'(rd_addr) < ROWS) ? mem[rd_addr] : '0;
    if (load) begin
      for (int i = 0; i < ROWS; i++) begin
        mem[i]     <= init_board[i];
        written[i] <= 1'b0;
      end
    end else if (wr_en && int'(wr_addr) < ROWS) begin
      mem[wr_addr]     <= wr_data;
      written[wr_addr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep non-full rows bottom-up in a queue, restack them at the bottom.
  task automatic compute_model();
    logic [COLS-1:0] surv[$];
    lowest_full = -1;
    exp_writes  = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (init_board[r] == FULL) begin
        if (lowest_full < 0) lowest_full = r;
      end else begin
        surv.push_back(init_board[r]);
        if (lowest_full >= 0) exp_writes++;
      end
    end
    exp_cnt    = ROWS - surv.size();
    exp_writes = exp_writes + exp_cnt;
    for (int r = 0; r < ROWS; r++)
      exp_board[r] = (ROWS - 1 - r < int'(surv.size())) ? surv[ROWS - 1 - r] : '0;
  endtask

  task automatic load_board();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic run(input string tag, input bit hold_start);
    int k, writes, busy_cyc, extra, bad_addr, untouched_hit;
    bit seen, first_busy, busy_at_done;
    compute_model();
    k = 0; writes = 0; busy_cyc = 0; extra = 0; bad_addr = 0; seen = 0;
    first_busy = 0; busy_at_done = 1;
    @(negedge clk) start = 1'b1;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (!hold_start) start = 1'b0;
      if (k == 1) first_busy = busy;
      if (wr_en) begin
        writes++;
        if (int'(wr_addr) >= ROWS) bad_addr++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1;
        busy_at_done = busy;
      end
    end
    check({tag, "/latency"}, k, 2 * ROWS + exp_cnt + 1);
    check({tag, "/busy_rise"}, first_busy, 1);
    check({tag, "/busy_at_done"}, busy_at_done, 0);
    check({tag, "/busy_cycles"}, busy_cyc, 2 * ROWS + exp_cnt);
    check({tag, "/writes"}, writes, exp_writes);
    check({tag, "/bad_addr"}, bad_addr, 0);
    // Start may still be high across the DONE edge; it must be ignored there.
    @(negedge clk);
    start = 1'b0;
    if (done) extra++;
    check({tag, "/lines_cleared"}, lines_cleared, exp_cnt);
`ifdef LINE_SCORE_EN
    score_model = score_model + (exp_cnt == 0 ? 0 : exp_cnt == 1 ? 40 : exp_cnt == 2 ? 100 :
                                 exp_cnt == 3 ? 300 : 1200);
    if (score_model > 65535) score_model = 65535;
    check({tag, "/score"}, score, score_model);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, "/no_restart"}, extra, 0);
    untouched_hit = 0;
    for (int r = lowest_full + 1; r < ROWS; r++)
      if (lowest_full >= 0 && written[r]) untouched_hit++;
    if (lowest_full < 0)
      for (int r = 0; r < ROWS; r++) if (written[r]) untouched_hit++;
    check({tag, "/untouched_rows"}, untouched_hit, 0);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s/row%0d", tag, r), mem[r], exp_board[r]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/wr_en"}, wr_en, 0);
    check({tag, "/rd_addr"}, rd_addr, 0);
    check({tag, "/wr_addr"}, wr_addr, 0);
    check({tag, "/wr_data"}, wr_data, 0);
    check({tag, "/lines_cleared"}, lines_cleared, 0);
`ifdef LINE_SCORE_EN
    check({tag, "/score"}, score, 0);
`endif
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    for (int r = 0; r < ROWS; r++) init_board[r] = '0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Empty board: no writes, 41-cycle latency.
    for (int r = 0; r < ROWS; r++) init_board[r] = '0;
    load_board();
    run("empty", 1'b0);

    // Only the bottom row full, distinct patterns above.
    for (int r = 0; r < ROWS; r++) init_board[r] = COLS'(r * 37 + 1);
    init_board[ROWS - 1] = FULL;
    load_board();
    run("bottom_full", 1'b0);

    // Four full rows at the bottom with a marker row above them.
    for (int r = 0; r < ROWS; r++) init_board[r] = COLS'(r * 11 + 3);
    for (int r = 16; r < ROWS; r++) init_board[r] = FULL;
    init_board[15] = 10'h155;
    load_board();
    run("tetris", 1'b0);

    // Two non-adjacent full rows.
    for (int r = 0; r < ROWS; r++) init_board[r] = COLS'(r + 100);
    init_board[5]  = FULL;
    init_board[12] = FULL;
    load_board();
    run("split", 1'b0);

    // Start held high through the whole run and the DONE cycle.
    for (int r = 0; r < ROWS; r++) init_board[r] = COLS'(r * 5 + 2);
    init_board[9] = FULL;
    load_board();
    run("held_start", 1'b1);

    // Reset asserted mid-FILL on a full board.
    for (int r = 0; r < ROWS; r++) init_board[r] = FULL;
    load_board();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (44) @(negedge clk);
    check("midfill/in_fill", {busy, wr_en, wr_data == '0}, 3'b111);
    reset = 1'b0;
    #1;
`ifdef LINE_SCORE_EN
    score_model = 0;
`endif
    check_reset_outputs("midfill_reset");
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midfill/no_done", dones, 0);
    reset = 1'b1;
    load_board();
    run("full_board", 1'b0);

    // Random boards, roughly one row in three full.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0) init_board[r] = FULL;
        else begin
          init_board[r] = COLS'($urandom);
          if (init_board[r] == FULL) init_board[r] = '0;
        end
      end
      load_board();
      run($sformatf("rand%0d", t), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
